// File: rtl/mem_defines.sv
// Shared memory-side types for the SDRAM line arbiter.
// Holds line request bundle, burst layout and address conversion.
package mem_defines;

    localparam int N_REQ              = 2;
    localparam int MEM_ACCESS_TIMEOUT = 128;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_CMD,
        ARB_XFER,
        ARB_DONE
    } arb_state_t;

    // Eight 16-bit words, w0 in bits [127:112].
    typedef logic [127:0] sdram_8_wd_t;
    typedef logic [23:0]  sdram_addr_t;

    typedef struct packed {
        logic        we;
        sdram_addr_t addr;
        sdram_8_wd_t wdata;
    } sdram_line_req_t;

    function automatic sdram_addr_t line_to_sdram_addr(input logic [20:0] line);
        return {line, 3'b000};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker, purely combinational.
// The requester that did not win last time gets priority on a tie.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    assign o_grant[0] = i_req[0] & (~i_req[1] |  i_last);
    assign o_grant[1] = i_req[1] & (~i_req[0] | ~i_last);

endmodule

// File: rtl/sdram_line_arbiter.sv
// Round-robin share of one SDRAM controller between I/D line engines.
// Optional watchdog: define SDRAM_ARB_TIMEOUT_EN.
module sdram_line_arbiter
    import mem_defines::*;
`ifdef SDRAM_ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT = MEM_ACCESS_TIMEOUT
)
`endif
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       req_we,
    input  logic [N_REQ-1:0][31:0] req_addr,
    input  sdram_8_wd_t [N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [N_REQ-1:0]       err,
    output sdram_8_wd_t            rdata,
    output logic                   sd_req,
    output logic                   sd_we,
    output sdram_addr_t            sd_addr,
    input  logic                   sd_ack,
    input  logic                   sd_wd_req,
    output logic [15:0]            sd_wdata,
    input  logic                   sd_rd_valid,
    input  logic [15:0]            sd_rdata
);

    arb_state_t      r_state;
    arb_state_t      w_next;
    logic [1:0]      r_gnt;
    logic [1:0]      w_pick;
    logic            w_idx;
    logic            r_last;
    sdram_line_req_t r_line;
    logic [2:0]      r_wcnt;
    sdram_8_wd_t     r_rdata;
    logic            w_strobe;
    logic            w_last_beat;
    logic [6:0]      w_wsel;
    logic            w_unused;

    assign w_unused = ^{req_addr[0][31:25], req_addr[0][3:0],
                        req_addr[1][31:25], req_addr[1][3:0]};

    rr_arb2 u_rr_arb2 (
        .i_req   (req),
        .i_last  (r_last),
        .o_grant (w_pick)
    );

    assign w_idx       = w_pick[1];
    assign w_strobe    = r_line.we ? sd_wd_req : sd_rd_valid;
    assign w_last_beat = (r_state == ARB_XFER) && w_strobe && (r_wcnt == 3'd7);
    // Top bit of word wcnt: 127 - 16*wcnt.
    assign w_wsel      = {~r_wcnt, 4'hF};

`ifdef SDRAM_ARB_TIMEOUT_EN
    logic [6:0] r_tmo;
    logic       r_err;
    logic       w_tmo;

    assign w_tmo = ((r_state == ARB_CMD) || (r_state == ARB_XFER))
                 && (r_tmo == 7'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else if ((r_state == ARB_IDLE) && (|req)) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else if ((r_state == ARB_CMD) || (r_state == ARB_XFER)) begin
            r_tmo <= r_tmo + 7'd1;
            if (w_tmo)
                r_err <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ARB_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ARB_IDLE: if (|req)       w_next = ARB_CMD;
            ARB_CMD:  if (sd_ack)     w_next = ARB_XFER;
            ARB_XFER: if (w_last_beat) w_next = ARB_DONE;
            ARB_DONE: w_next = ARB_IDLE;
            default:  w_next = ARB_IDLE;
        endcase
`ifdef SDRAM_ARB_TIMEOUT_EN
        if (w_tmo)
            w_next = ARB_DONE;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt   <= '0;
            r_last  <= 1'b1;
            r_line  <= '0;
            r_wcnt  <= '0;
            r_rdata <= '0;
        end else begin
            unique case (r_state)
                ARB_IDLE: begin
                    if (|req) begin
                        r_gnt        <= w_pick;
                        r_line.we    <= req_we[w_idx];
                        r_line.addr  <= line_to_sdram_addr(req_addr[w_idx][24:4]);
                        r_line.wdata <= req_wdata[w_idx];
                        r_wcnt       <= '0;
                    end
                end
                ARB_XFER: begin
                    if (w_strobe) begin
                        r_wcnt <= r_wcnt + 3'd1;
                        if (!r_line.we)
                            r_rdata[w_wsel -: 16] <= sd_rdata;
                    end
                end
                ARB_DONE: begin
                    r_last <= r_gnt[1];
                    r_gnt  <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt      = r_gnt;
        done     = '0;
        err      = '0;
        rdata    = r_rdata;
        sd_req   = 1'b0;
        sd_we    = 1'b0;
        sd_addr  = '0;
        sd_wdata = '0;
        unique case (r_state)
            ARB_CMD: begin
                sd_req  = 1'b1;
                sd_we   = r_line.we;
                sd_addr = r_line.addr;
            end
            ARB_XFER: begin
                if (r_line.we)
                    sd_wdata = r_line.wdata[w_wsel -: 16];
            end
            ARB_DONE: begin
                done = r_gnt;
`ifdef SDRAM_ARB_TIMEOUT_EN
                err  = r_err ? r_gnt : 2'b00;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_line_arbiter.sv
// Self-checking bench for sdram_line_arbiter.
// Bench acts as the SDRAM controller; define SDRAM_ARB_TIMEOUT_EN for watchdog run.
module tb_sdram_line_arbiter;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          req;
    logic [1:0]          req_we;
    logic [1:0][31:0]    req_addr;
    logic [1:0][127:0]   req_wdata;
    logic [1:0]          gnt;
    logic [1:0]          done;
    logic [1:0]          err;
    logic [127:0]        rdata;
    logic                sd_req;
    logic                sd_we;
    logic [23:0]         sd_addr;
    logic                sd_ack;
    logic                sd_wd_req;
    logic [15:0]         sd_wdata;
    logic                sd_rd_valid;
    logic [15:0]         sd_rdata;

    int total = 0;
    int bad   = 0;

    // Reference state: who won last, and what rdata should hold.
    int           m_last;
    logic [127:0] m_rd;

    always #5 clk = ~clk;

    sdram_line_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .sd_req      (sd_req),
        .sd_we       (sd_we),
        .sd_addr     (sd_addr),
        .sd_ack      (sd_ack),
        .sd_wd_req   (sd_wd_req),
        .sd_wdata    (sd_wdata),
        .sd_rd_valid (sd_rd_valid),
        .sd_rdata    (sd_rdata)
    );

    typedef struct {
        int           id;
        bit           we;
        logic [31:0]  addr;
        logic [127:0] data;
        int           ack;
        int           gap;
        logic [23:0]  e_addr;
        logic [127:0] e_rd;
    } vec_t;

    vec_t tbl[4];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] m_addr(input logic [31:0] a);
        longint unsigned line;
        line = (longint'(a) / 16) % (64'd1 << 21);
        return 24'(line * 8);
    endfunction

    function automatic int m_pick(input logic [1:0] r);
        if (r == 2'b11)
            return (m_last == 1) ? 0 : 1;
        return (r == 2'b01) ? 0 : 1;
    endfunction

    // Entered at the negedge after the grant edge (DUT in command phase).
    task automatic serve(input int id, input logic [23:0] e_addr,
                         input logic [127:0] e_rd, input int ack_dly,
                         input int gap, input bit drop);
        bit           we;
        logic [127:0] line;
        logic [1:0]   oh;
        we   = req_we[id];
        line = we ? req_wdata[id] : e_rd;
        oh   = 2'(1 << id);
        chk("gnt", gnt, oh);
        chk("sd_req", sd_req, 1);
        chk("sd_addr", sd_addr, e_addr);
        chk("sd_we", sd_we, we);
        repeat (ack_dly) begin
            tick();
            chk("sd_req_hold", sd_req, 1);
        end
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        chk("sd_req_drop", sd_req, 0);
        for (int k = 0; k < 8; k++) begin
            repeat (gap) begin
                if (we) begin
                    sd_rd_valid = 1'b1;
                    sd_rdata    = 16'($urandom);
                end else begin
                    sd_wd_req = 1'b1;
                end
                tick();
                sd_rd_valid = 1'b0;
                sd_wd_req   = 1'b0;
            end
            chk("done_early", done, 0);
            if (we) begin
                chk("sd_wdata", sd_wdata, 16'(line >> (16 * (7 - k))));
                sd_wd_req = 1'b1;
            end else begin
                sd_rd_valid = 1'b1;
                sd_rdata    = 16'(line >> (16 * (7 - k)));
            end
            if (drop && k == 3)
                req[id] = 1'b0;
            tick();
            sd_wd_req   = 1'b0;
            sd_rd_valid = 1'b0;
        end
        chk("done", done, oh);
        chk("err", err, 0);
        chk("gnt_done", gnt, oh);
        chk("rdata", rdata, e_rd);
        req[id] = 1'b0;
        m_last  = id;
        m_rd    = e_rd;
        tick();
        chk("done_pulse", done, 0);
        chk("gnt_clear", gnt, 0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_gnt"}, gnt, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_err"}, err, 0);
        chk({nm, "_rdata"}, rdata, 0);
        chk({nm, "_sdreq"}, sd_req, 0);
        chk({nm, "_sdwe"}, sd_we, 0);
        chk({nm, "_sdaddr"}, sd_addr, 0);
        chk({nm, "_sdwdata"}, sd_wdata, 0);
    endtask

    initial begin
        int          w;
        logic [1:0]  pat;
        logic [127:0] lines [2];
        int          ackd [2];
        int          gapd [2];

        tbl[0] = '{0, 1'b0, 32'h0000_1230,
                   128'h1111_2222_3333_4444_5555_6666_7777_8888, 2, 0,
                   24'h000918, 128'h1111_2222_3333_4444_5555_6666_7777_8888};
        tbl[1] = '{1, 1'b1, 32'h0100_0000,
                   128'hA0A0_A1A1_A2A2_A3A3_A4A4_A5A5_A6A6_A7A7, 0, 1,
                   24'h800000, 128'h1111_2222_3333_4444_5555_6666_7777_8888};
        tbl[2] = '{0, 1'b0, 32'hFFFF_FFFF,
                   128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98, 0, 0,
                   24'hFFFFF8, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98};
        tbl[3] = '{1, 1'b0, 32'h0000_0010,
                   128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878, 1, 2,
                   24'h000008, 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878};

        rst         = 1'b1;
        req         = '0;
        req_we      = '0;
        req_addr    = '0;
        req_wdata   = '0;
        sd_ack      = 1'b0;
        sd_wd_req   = 1'b0;
        sd_rd_valid = 1'b0;
        sd_rdata    = '0;
        m_last      = 1;
        m_rd        = '0;
        repeat (2) tick();
        chk_zero("rst");
        rst = 1'b0;
        tick();
        chk_zero("post_rst");

        // Stray read strobe while idle must not touch rdata.
        sd_rd_valid = 1'b1;
        sd_rdata    = 16'hBEEF;
        tick();
        sd_rd_valid = 1'b0;
        chk("stray_idle", rdata, 0);

        // Collision out of reset, twice: I-cache first both times.
        for (int r = 0; r < 2; r++) begin
            req_we    = 2'b00;
            req_addr  = {32'h0000_4440, 32'h0000_2220};
            lines[0]  = {4{$urandom}};
            lines[1]  = {4{$urandom}};
            req       = 2'b11;
            tick();
            w = m_pick(2'b11);
            chk("rr_first", w, 0);
            serve(w, m_addr(req_addr[w]), lines[w], 1, 0, 0);
            tick();
            serve(1 - w, m_addr(req_addr[1 - w]), lines[1 - w], 0, 0, 0);
        end

        for (int i = 0; i < 4; i++) begin
            req_we[tbl[i].id]    = tbl[i].we;
            req_addr[tbl[i].id]  = tbl[i].addr;
            req_wdata[tbl[i].id] = tbl[i].we ? tbl[i].data : 128'(0);
            req[tbl[i].id]       = 1'b1;
            tick();
            serve(tbl[i].id, tbl[i].e_addr, tbl[i].e_rd,
                  tbl[i].ack, tbl[i].gap, 0);
        end

        // Write with req dropped mid-burst: still 8 beats, rdata kept.
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'h0000_0A50;
        req_wdata[1] = 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F;
        req[1]       = 1'b1;
        tick();
        serve(1, 24'h000528, m_rd, 1, 1, 1);

        for (int n = 0; n < 16; n++) begin
            pat = 2'($urandom_range(1, 3));
            for (int j = 0; j < 2; j++) begin
                req_we[j]    = 1'($urandom);
                req_addr[j]  = $urandom;
                req_wdata[j] = {$urandom, $urandom, $urandom, $urandom};
                lines[j]     = {$urandom, $urandom, $urandom, $urandom};
                ackd[j]      = $urandom_range(0, 3);
                gapd[j]      = $urandom_range(0, 2);
            end
            req = pat;
            tick();
            w = m_pick(pat);
            serve(w, m_addr(req_addr[w]), req_we[w] ? m_rd : lines[w],
                  ackd[w], gapd[w], 0);
            if (pat == 2'b11) begin
                tick();
                w = 1 - w;
                serve(w, m_addr(req_addr[w]), req_we[w] ? m_rd : lines[w],
                      ackd[w], gapd[w], 0);
            end
        end

        // Reset after four read beats.
        req_we[0]   = 1'b0;
        req_addr[0] = 32'h0000_3000;
        req[0]      = 1'b1;
        tick();
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sd_rd_valid = 1'b1;
            sd_rdata    = 16'hC000 + 16'(k);
            tick();
        end
        sd_rd_valid = 1'b0;
        rst         = 1'b1;
        req         = '0;
        tick();
        chk_zero("mid_rst");
        rst    = 1'b0;
        m_last = 1;
        m_rd   = '0;
        tick();
        req[0] = 1'b1;
        tick();
        serve(0, 24'h001800, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 0, 0, 0);

`ifdef SDRAM_ARB_TIMEOUT_EN
        begin
            int cnt;
            bit seen;
            cnt       = 0;
            seen      = 1'b0;
            req_we[1] = 1'b0;
            req[1]    = 1'b1;
            tick();
            for (int c = 0; c < 300 && !seen; c++) begin
                if (done != 0)
                    seen = 1'b1;
                else begin
                    if (sd_req)
                        cnt++;
                    tick();
                end
            end
            chk("tmo_seen", seen, 1);
            chk("tmo_done", done, 2'b10);
            chk("tmo_err", err, 2'b10);
            chk("tmo_cycles", cnt, 128);
            req[1] = 1'b0;
            tick();
            chk("tmo_idle_gnt", gnt, 0);
            chk("tmo_idle_req", sd_req, 0);
            chk("tmo_idle_done", done, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
